// File: rtl/out_capture_buffer.sv
// Captures strobed CPU output words into a first-word-fall-through FIFO with a
// valid/ready drain port, and raises startIO once a post-reset delay expires.
// Optional per-word cycle stamps are enabled with the OUTCAPTURE_TIMESTAMP_EN macro.
module out_capture_buffer #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned START_DELAY = 531030,
  parameter int unsigned DLYWIDTH    = 24,
  parameter int unsigned MODE        = 0,
  parameter int unsigned TSWIDTH     = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     outFlag,
  input  logic [WIDTH-1:0]         out,
  input  logic                     clear,
  output logic                     startIO,
  input  logic                     rdReady,
  output logic                     rdValid,
  output logic [WIDTH-1:0]         rdData,
  output logic [TSWIDTH-1:0]       rdTimestamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              dropped,
  output logic                     halted
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned TARGET = (START_DELAY == 0) ? 1 : START_DELAY;
  localparam logic [DLYWIDTH-1:0] DLY_LAST  = DLYWIDTH'(TARGET - 1);
  localparam logic [CW-1:0]       FULL_CNT  = CW'(DEPTH);
  localparam logic                OVERWRITE = (MODE != 0);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DLYWIDTH-1:0] dly_cnt;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [WIDTH-1:0]    mem [DEPTH];

  logic full;
  logic push;
  logic pop;
  logic lose;
  logic write_en;

  assign full     = (count == FULL_CNT);
  assign rdValid  = (count != '0);
  assign push     = outFlag & (state_q != ST_HALT) & ~clear;
  assign pop      = rdValid & rdReady & ~clear;
  assign lose     = push & full & ~pop;
  // In stop mode a lost word is never written; in overwrite mode it replaces the head.
  assign write_en = push & (~lose | OVERWRITE);
  assign rdData   = rdValid ? mem[rd_ptr] : '0;

  // Next-state logic: delay expiry, stop-on-full, and clear-driven resume.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT: begin
        if (dly_cnt == DLY_LAST) state_d = ST_RUN;
        if (lose && !OVERWRITE)  state_d = ST_HALT;
      end
      ST_RUN: begin
        if (lose && !OVERWRITE) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (clear) state_d = ST_RUN;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // State register, start delay and control outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_WAIT;
      dly_cnt <= '0;
      startIO <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_WAIT) dly_cnt <= dly_cnt + DLYWIDTH'(1);
      startIO <= startIO | (state_d != ST_WAIT);
      halted  <= (state_d == ST_HALT);
    end
  end

  // Pointers, occupancy and loss accounting.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else begin
      if (write_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop || (lose && OVERWRITE)) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop && !full)      count <= count + CW'(1);
      else if (pop && !push)          count <= count - CW'(1);
      if (lose) begin
        overflow <= 1'b1;
        if (dropped != 16'hFFFF) dropped <= dropped + 16'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (write_en) mem[wr_ptr] <= out;
  end

`ifdef OUTCAPTURE_TIMESTAMP_EN
  logic [TSWIDTH-1:0] ts_cnt;
  logic [TSWIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TSWIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (write_en) ts_mem[wr_ptr] <= ts_cnt;
  end

  assign rdTimestamp = rdValid ? ts_mem[rd_ptr] : '0;
`else
  assign rdTimestamp = '0;
`endif

endmodule

// File: tb/tb_out_capture_buffer.sv
// Directed bench: one stop-mode and one overwrite-mode instance share stimulus.
module tb_out_capture_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        outFlag;
  logic [23:0] out;
  logic        clear;
  logic        rdReady;

  logic        m0_startIO, m1_startIO, m0_rdValid, m1_rdValid;
  logic [23:0] m0_rdData, m1_rdData;
  logic [15:0] m0_rdTimestamp, m1_rdTimestamp;
  logic [2:0]  m0_count, m1_count;
  logic        m0_overflow, m1_overflow, m0_halted, m1_halted;
  logic [15:0] m0_dropped, m1_dropped;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] tb_ts    = '0;
  logic [15:0] ts_q [3];

  always #5 clock = ~clock;

  // Reference cycle counter matching the optional stamp counter.
  always @(posedge clock) tb_ts <= reset ? 16'd0 : tb_ts + 16'd1;

  out_capture_buffer #(.WIDTH(24), .DEPTH(4), .START_DELAY(5), .DLYWIDTH(24),
                       .MODE(0), .TSWIDTH(16)) u_m0 (
    .clock(clock), .reset(reset), .outFlag(outFlag), .out(out), .clear(clear),
    .startIO(m0_startIO), .rdReady(rdReady), .rdValid(m0_rdValid),
    .rdData(m0_rdData), .rdTimestamp(m0_rdTimestamp), .count(m0_count),
    .overflow(m0_overflow), .dropped(m0_dropped), .halted(m0_halted));

  out_capture_buffer #(.WIDTH(24), .DEPTH(4), .START_DELAY(5), .DLYWIDTH(24),
                       .MODE(1), .TSWIDTH(16)) u_m1 (
    .clock(clock), .reset(reset), .outFlag(outFlag), .out(out), .clear(clear),
    .startIO(m1_startIO), .rdReady(rdReady), .rdValid(m1_rdValid),
    .rdData(m1_rdData), .rdTimestamp(m1_rdTimestamp), .count(m1_count),
    .overflow(m1_overflow), .dropped(m1_dropped), .halted(m1_halted));

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stamp(input logic [15:0] t);
`ifdef OUTCAPTURE_TIMESTAMP_EN
    return 32'(t);
`else
    return 32'(t & 16'h0);
`endif
  endfunction

  initial begin
    reset = 1'b1; outFlag = 1'b0; out = '0; clear = 1'b0; rdReady = 1'b0;
    step; step;
    chk("rst_startIO",  32'(m0_startIO), 32'd0);
    chk("rst_rdValid",  32'(m0_rdValid), 32'd0);
    chk("rst_rdData",   32'(m0_rdData), 32'd0);
    chk("rst_rdTs",     32'(m0_rdTimestamp), 32'd0);
    chk("rst_count",    32'(m0_count), 32'd0);
    chk("rst_overflow", 32'(m0_overflow), 32'd0);
    chk("rst_dropped",  32'(m0_dropped), 32'd0);
    chk("rst_halted",   32'(m0_halted), 32'd0);
    chk("rst_m1_start", 32'(m1_startIO), 32'd0);
    reset = 1'b0;

    // Start delay: low through edge 4, high from edge 5.
    for (int k = 1; k <= 5; k++) begin
      step;
      chk("dly_m0_startIO", 32'(m0_startIO), (k == 5) ? 32'd1 : 32'd0);
      chk("dly_m1_startIO", 32'(m1_startIO), (k == 5) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 100; k++) begin
      step;
      chk("hold_startIO", 32'(m0_startIO), 32'd1);
    end

    // Basic fill then drain in order.
    for (int i = 0; i < 3; i++) begin
      outFlag = 1'b1; out = 24'(i + 1); ts_q[i] = tb_ts;
      step;
    end
    outFlag = 1'b0;
    chk("fill_count",   32'(m0_count), 32'd3);
    chk("fill_rdValid", 32'(m0_rdValid), 32'd1);
    chk("fill_head",    32'(m0_rdData), 32'd1);
    rdReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain_data",  32'(m0_rdData), 32'(i + 1));
      chk("drain_m1",    32'(m1_rdData), 32'(i + 1));
      chk("drain_stamp", 32'(m0_rdTimestamp), stamp(ts_q[i]));
      step;
    end
    chk("drain_rdValid", 32'(m0_rdValid), 32'd0);
    chk("drain_count",   32'(m0_count), 32'd0);
    rdReady = 1'b0;

    // Push six words with no reads: stop mode vs overwrite mode.
    for (int i = 1; i <= 6; i++) begin
      outFlag = 1'b1; out = 24'(i);
      step;
    end
    outFlag = 1'b0;
    chk("m0_full_count",    32'(m0_count), 32'd4);
    chk("m0_full_overflow", 32'(m0_overflow), 32'd1);
    chk("m0_full_dropped",  32'(m0_dropped), 32'd1);
    chk("m0_full_halted",   32'(m0_halted), 32'd1);
    chk("m0_full_head",     32'(m0_rdData), 32'd1);
    chk("m1_full_count",    32'(m1_count), 32'd4);
    chk("m1_full_overflow", 32'(m1_overflow), 32'd1);
    chk("m1_full_dropped",  32'(m1_dropped), 32'd2);
    chk("m1_full_halted",   32'(m1_halted), 32'd0);
    rdReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("m0_ovf_order", 32'(m0_rdData), 32'(i + 1));
      chk("m1_ovf_order", 32'(m1_rdData), 32'(i + 3));
      step;
    end
    rdReady = 1'b0;
    chk("m0_empty_halted", 32'(m0_halted), 32'd1);
    chk("m1_empty_count",  32'(m1_count), 32'd0);
    clear = 1'b1;
    step;
    clear = 1'b0;
    chk("clr_count",    32'(m0_count), 32'd0);
    chk("clr_halted",   32'(m0_halted), 32'd0);
    chk("clr_overflow", 32'(m0_overflow), 32'd0);
    chk("clr_dropped",  32'(m0_dropped), 32'd0);
    chk("clr_startIO",  32'(m0_startIO), 32'd1);
    chk("clr_m1_drop",  32'(m1_dropped), 32'd0);

    // Full FIFO streaming: push and pop every cycle, no loss.
    for (int i = 0; i < 4; i++) begin
      outFlag = 1'b1; out = 24'h10 + 24'(i);
      step;
    end
    rdReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      out = 24'h14 + 24'(i);
      chk("stream_m0_data",  32'(m0_rdData), 32'h10 + 32'(i));
      chk("stream_m1_data",  32'(m1_rdData), 32'h10 + 32'(i));
      chk("stream_m0_count", 32'(m0_count), 32'd4);
      step;
    end
    outFlag = 1'b0;
    chk("stream_m0_count_end", 32'(m0_count), 32'd4);
    chk("stream_m0_dropped",   32'(m0_dropped), 32'd0);
    chk("stream_m1_dropped",   32'(m1_dropped), 32'd0);
    chk("stream_m0_overflow",  32'(m0_overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("tail_data", 32'(m0_rdData), 32'h1a + 32'(i));
      step;
    end
    chk("tail_rdValid", 32'(m0_rdValid), 32'd0);
    rdReady = 1'b0;

    // Reset mid-operation drops contents and restarts the delay.
    outFlag = 1'b1; out = 24'h55;
    step;
    outFlag = 1'b0;
    chk("pre_rst_count", 32'(m0_count), 32'd1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("mid_rst_count",   32'(m0_count), 32'd0);
    chk("mid_rst_startIO", 32'(m0_startIO), 32'd0);
    chk("mid_rst_rdValid", 32'(m1_rdValid), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step;
      chk("redly_startIO", 32'(m0_startIO), (k == 5) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/out_capture_buffer.md
Name: out_capture_buffer

Overview:
- Synthesizable successor to the CPU output-debug harness. Generates the delayed `startIO` trigger from an internal cycle counter, replacing the fixed bench delay.
- Captures every CPU output word (`out` qualified by `outFlag`) into a parametrised FIFO.
- Exposes a valid/ready drain port for a host or UART.
- Sits between the CPU's I/O outputs and the board debug path.

Parameters:
- WIDTH, 24, CPU output word width.
- DEPTH, 16, FIFO entries; power of two, >=2.
- START_DELAY, 531030, clock edges after reset release before `startIO` asserts (531030 x 20 ns = 10.6206 ms).
- DLYWIDTH, 24, delay counter width; must hold START_DELAY.
- MODE, 0, full policy: 0 = stop (halt capture), 1 = overwrite oldest.
- TSWIDTH, 16, timestamp width (used only with the optional feature).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- outFlag  in  1  CPU output strobe; `out` valid this cycle
- out  in  WIDTH  CPU output word
- clear  in  1  synchronous flush of FIFO, overflow and dropped counter
- startIO  out  1  start trigger to CPU
- rdReady  in  1  host accepts head word
- rdValid  out  1  head word available
- rdData  out  WIDTH  head word
- rdTimestamp  out  TSWIDTH  cycle stamp of head word
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: at least one word lost or overwritten
- dropped  out  16  words lost; saturates at 16'hFFFF
- halted  out  1  capture stopped (MODE 0 only)

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`, sampled on the rising edge; it overrides everything, including `clear`.
- Reset values: `startIO`=0, `rdValid`=0, `rdData`=0, `rdTimestamp`=0, `count`=0, `overflow`=0, `dropped`=0, `halted`=0. Delay counter and pointers are 0; state is WAIT.
- States:
  - WAIT: delay counter increments each edge. At the edge where the counter reaches max(START_DELAY,1), go to RUN and register `startIO`=1.
  - RUN: `startIO` held at 1.
  - HALT: `startIO` held at 1; `halted`=1.
  - `startIO` never falls except on reset.
- Capture: enabled in WAIT and RUN, disabled in HALT. A push occurs on an edge where `outFlag`=1 and capture is enabled.
- FIFO is first-word-fall-through:
  - `rdValid` = (`count`!=0).
  - `rdData` and `rdTimestamp` show the head entry.
  - A word pushed into an empty FIFO at edge n is visible with `rdValid`=1 after edge n.
- Pop: occurs on an edge where `rdValid`&&`rdReady`.
- Simultaneous push and pop:
  - Not empty: both happen, `count` unchanged.
  - Empty: push only; `rdValid` rises next cycle.
- Full (`count`==DEPTH) with push and no pop:
  - MODE 0: word discarded; `overflow`=1; `dropped`+=1; state goes to HALT.
  - MODE 1: oldest entry discarded and new word written; `count` stays DEPTH; `overflow`=1; `dropped`+=1; state unchanged.
- Full with push and pop: normal simultaneous case, no loss.
- `clear`=1:
  - Next edge: `count`=0, pointers reset, `overflow`=0, `dropped`=0.
  - If in HALT, return to RUN.
  - The delay counter and WAIT state are unaffected.
  - A push or pop in the same cycle is ignored.
- Pointers: `$clog2(DEPTH)` bits, wrap modulo DEPTH. `count` is maintained separately so full and empty are unambiguous.
- Reset mid-operation: FIFO contents are lost, `startIO` returns to 0 and the delay restarts from 0.

Optional Feature:
- Macro OUTCAPTURE_TIMESTAMP_EN.
- Defined:
  - A free-running TSWIDTH-bit cycle counter (0 at reset, wraps) is added.
  - Each pushed word stores the counter value of its push edge alongside it.
  - `rdTimestamp` shows the head's stamp; in MODE 1 overwrite, the stamp is replaced together with the data.
- Undefined: no counter or stamp storage; `rdTimestamp` is tied to 0.

Test Plan:
- START_DELAY=5, `reset` high for 2 edges then low -> `startIO` stays 0 for edges 1-4, is 1 after edge 5, and remains 1 for 100 cycles.
- DEPTH=4, `rdReady`=0, push 24'h000001..24'h000003 on consecutive cycles -> `count`=3, `rdData`=24'h000001; then `rdReady`=1 for 3 cycles -> `rdData` shows 1,2,3 in order, then `rdValid`=0.
- MODE 0, DEPTH=4, push 6 words (1..6) with `rdReady`=0 -> `count`=4, `overflow`=1, `dropped`=1, `halted`=1; the 6th strobe is ignored (`dropped` stays 1). Pulse `clear` -> `count`=0, `halted`=0, `startIO` still 1.
- MODE 1, DEPTH=4, push 1..6 with `rdReady`=0 -> `count`=4, `dropped`=2, drain order 3,4,5,6.
- Full FIFO with `outFlag`=1 and `rdReady`=1 for 10 cycles -> `count` stays 4, `dropped` unchanged, output stream in order with no gaps.
- OUTCAPTURE_TIMESTAMP_EN defined, pushes at cycles 10 and 13 after reset -> `rdTimestamp` reads 10 then 13; without the macro, `rdTimestamp` is always 0.
